muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_muldiv_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with architectural HI/LO: fixed-latency multiply,
// iterative restoring divide, and MTHI/MTLO moves.
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   srca,
    input  logic [WIDTH-1:0]   srcb,
    input  logic               cancel,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] hilo,
    output logic               div_zero,
    output logic [1:0]         state_dbg
);
    // Handshake: a request is accepted on any edge where start=1, cancel=0 and
    // busy=0; busy then stays high until the done edge or an abort.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               signed_op;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               q_neg;
    logic               r_neg;
    logic               mul_last;
    logic               div_last;

    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign mul_last  = (cnt == CW'(MUL_CYCLES - 1));
    assign div_last  = (cnt == CW'(WIDTH));

    always_comb begin
        // Sign-extending to 2*WIDTH makes one unsigned multiply serve both forms.
        ext_a   = {{WIDTH{signed_op & opa[WIDTH-1]}}, opa};
        ext_b   = {{WIDTH{signed_op & opb[WIDTH-1]}}, opb};
        product = ext_a * ext_b;
        dvs     = (signed_op && opb[WIDTH-1]) ? -opb : opb;
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        q_neg   = signed_op & (opa[WIDTH-1] ^ opb[WIDTH-1]);
        r_neg   = signed_op & opa[WIDTH-1];
        quo_fix = q_neg ? -quo : quo;
        rem_fix = r_neg ? -rem : rem;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            signed_op <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            quo       <= '0;
            rem       <= '0;
            hilo      <= '0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        case (op)
                            3'b000, 3'b001: begin
                                opa       <= srca;
                                opb       <= srcb;
                                signed_op <= ~op[0];
                                cnt       <= '0;
                                state     <= MUL;
                            end
                            3'b010, 3'b011: begin
                                opa       <= srca;
                                opb       <= srcb;
                                signed_op <= ~op[0];
                                cnt       <= '0;
                                rem       <= '0;
                                quo       <= (!op[0] && srca[WIDTH-1]) ? -srca : srca;
                                state     <= DIV;
                            end
                            3'b100:  hilo[2*WIDTH-1:WIDTH] <= srca;
                            3'b101:  hilo[WIDTH-1:0]       <= srca;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        hilo  <= product;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (cancel) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV: begin
                    // Completion takes priority over a same-cycle cancel.
                    if (div_last) begin
                        if (opb == '0) begin
                            hilo     <= {opa, {WIDTH{1'b1}}};
                            div_zero <= 1'b1;
                        end else begin
                            hilo     <= {rem_fix, quo_fix};
                            div_zero <= 1'b0;
                        end
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (cancel) begin
                        state <= IDLE;
                    end else begin
                        rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus randomized ops, checked
// against an arithmetic reference model of HI/LO and the divide-by-zero flag.
module tb_muldiv_unit;
    localparam int W  = 32;
    localparam int MC = 2;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic           clk    = 1'b0;
    logic           resetn = 1'b0;
    logic           start  = 1'b0;
    logic           cancel = 1'b0;
    logic [2:0]     op     = 3'b000;
    logic [W-1:0]   srca   = '0;
    logic [W-1:0]   srcb   = '0;
    logic           busy;
    logic           done;
    logic           div_zero;
    logic [2*W-1:0] hilo;
    logic [1:0]     state_dbg;

    int          n_checks   = 0;
    int          n_errors   = 0;
    logic [63:0] model_hilo = '0;
    logic        model_dz   = 1'b0;
    logic [64:0] exp_q[$];

    muldiv_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .op        (op),
        .srca      (srca),
        .srcb      (srcb),
        .cancel    (cancel),
        .busy      (busy),
        .done      (done),
        .hilo      (hilo),
        .div_zero  (div_zero),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: architectural {div_zero, HI, LO} after an op completes.
    function automatic logic [64:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p, qv, rv;
        logic [64:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = {model_dz, model_hilo};
        case (o)
            OP_MULT: begin
                p   = sa * sb;
                res = {model_dz, p};
            end
            OP_MULTU: begin
                p   = {32'b0, a} * {32'b0, b};
                res = {model_dz, p};
            end
            OP_DIV, OP_DIVU: begin
                if (b == 32'h0) begin
                    res = {1'b1, a, 32'hFFFF_FFFF};
                end else if (o == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    res = {1'b0, 32'h0, 32'h8000_0000};
                end else begin
                    if (o == OP_DIV) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = longint'({32'b0, a}) / longint'({32'b0, b});
                        r = longint'({32'b0, a}) % longint'({32'b0, b});
                    end
                    qv  = q;
                    rv  = r;
                    res = {1'b0, rv[31:0], qv[31:0]};
                end
            end
            OP_MTHI: res = {model_dz, a, model_hilo[31:0]};
            OP_MTLO: res = {model_dz, model_hilo[63:32], a};
            default: res = {model_dz, model_hilo};
        endcase
        return res;
    endfunction

    // driver: one op; cancel_cyc>0 raises cancel for the edge that many cycles
    // after the start edge; noisy drives spurious MTHI starts while busy.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int cancel_cyc, input bit noisy);
        logic [64:0] exp;
        logic [64:0] prev;
        int          exp_lat;
        int          lat;
        bit          aborted;
        bit          seen_done;
        prev    = {model_dz, model_hilo};
        exp     = ref_result(o, a, b);
        exp_lat = (o[2:1] == 2'b00) ? MC : (o[2:1] == 2'b01) ? W + 1 : 0;
        aborted = (exp_lat > 0) && (cancel_cyc > 0) && (cancel_cyc < exp_lat);
        if (!aborted) begin
            model_dz   = exp[64];
            model_hilo = exp[63:0];
            if (exp_lat > 0) exp_q.push_back(exp);
        end
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = b;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_low_after_start", 65'(done), 65'(0));
        if (exp_lat == 0) begin
            check("mt_busy", 65'(busy), 65'(0));
            check("mt_state", {div_zero, hilo}, {model_dz, model_hilo});
            return;
        end
        check("busy_on_start", 65'(busy), 65'(1));
        lat = 0;
        while (1) begin
            if (cancel_cyc > 0 && lat == cancel_cyc - 1) cancel = 1'b1;
            if (noisy) begin
                start = 1'b1; op = OP_MTHI; srca = $urandom;
            end
            @(posedge clk); #1;
            lat++;
            cancel = 1'b0;
            start  = 1'b0;
            if (done || lat >= exp_lat || (aborted && lat == cancel_cyc)) break;
            check("busy_mid", 65'(busy), 65'(1));
            check("hilo_hold", {div_zero, hilo}, prev);
        end
        if (aborted) begin
            check("abort_busy", 65'(busy), 65'(0));
            check("abort_done", 65'(done), 65'(0));
            check("abort_hilo", {div_zero, hilo}, prev);
            seen_done = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (done) seen_done = 1'b1;
            end
            check("abort_no_late_done", 65'(seen_done), 65'(0));
            check("abort_hilo_later", {div_zero, hilo}, prev);
        end else begin
            check("latency", 65'(lat), 65'(exp_lat));
            check("done_pulse", 65'(done), 65'(1));
            check("busy_low_at_done", 65'(busy), 65'(0));
            check("result", {div_zero, hilo}, exp_q.pop_front());
        end
    endtask

    task automatic start_with_cancel(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = o; srca = a; srcb = b;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        check("sc_busy", 65'(busy), 65'(0));
        check("sc_state", {div_zero, hilo}, {model_dz, model_hilo});
        @(posedge clk); #1;
        check("sc_busy_later", 65'(busy), 65'(0));
        check("sc_done_later", 65'(done), 65'(0));
    endtask

    task automatic reset_mid_div();
        @(negedge clk);
        start = 1'b1; op = OP_DIV; srca = 32'h0000_1234; srcb = 32'h0000_0005;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("rst_async_hilo", 65'(hilo), 65'(0));
        check("rst_async_busy", 65'(busy), 65'(0));
        check("rst_async_done", 65'(done), 65'(0));
        check("rst_async_dz", 65'(div_zero), 65'(0));
        model_hilo = '0;
        model_dz   = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        // next start is accepted on the first edge after release
        do_op(OP_MULT, 32'h0000_0003, 32'hFFFF_FFFB, 0, 0);
        check("rst_post_mult", 65'(hilo), {1'b0, 64'hFFFF_FFFF_FFFF_FFF1});
    endtask

    // stimulus
    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          rc;
        bit          rn;

        repeat (3) @(posedge clk);
        #1;
        check("reset_hilo", 65'(hilo), 65'(0));
        check("reset_busy", 65'(busy), 65'(0));
        check("reset_done", 65'(done), 65'(0));
        check("reset_dz", 65'(div_zero), 65'(0));
        resetn = 1'b1;

        do_op(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0);
        check("mult_const", 65'(hilo), {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0);
        check("multu_const", 65'(hilo), {1'b0, 64'h0000_0001_FFFF_FFFE});
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
        check("div_neg_const", 65'(hilo), {1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
        do_op(OP_DIVU, 32'h0000_0007, 32'h0000_0002, 0, 0);
        do_op(OP_DIVU, 32'h1234_5678, 32'h0000_0000, 0, 0);
        check("divz_const", {div_zero, hilo}, {1'b1, 64'h1234_5678_FFFF_FFFF});
        do_op(OP_DIV, 32'h0000_0006, 32'h0000_0003, 0, 0);
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("div_ovf_const", {div_zero, hilo}, {1'b0, 64'h0000_0000_8000_0000});
        do_op(OP_DIV, 32'h0000_0064, 32'h0000_0007, 10, 0);
        do_op(OP_MTHI, 32'hA5A5_A5A5, 32'h0, 0, 0);
        do_op(OP_MTLO, 32'h5A5A_0001, 32'h0, 0, 0);
        do_op(OP_MULT, 32'h0000_1234, 32'hFFFF_0000, MC, 0);
        do_op(OP_DIVU, 32'hDEAD_BEEF, 32'h0000_1234, W + 1, 0);
        do_op(OP_MULTU, 32'h0000_0003, 32'h0000_0005, 1, 0);
        do_op(OP_DIV, 32'hFFFF_FF9C, 32'h0000_0009, 0, 1);
        start_with_cancel(OP_MTHI, 32'h1111_2222, 32'h0);
        start_with_cancel(OP_DIV, 32'h0000_000A, 32'h0000_0002);
        do_op(3'b110, 32'hCAFE_F00D, 32'h1, 0, 0);
        do_op(3'b111, 32'hCAFE_F00D, 32'h1, 0, 0);
        do_op(OP_DIVU, 32'h0000_0005, 32'h0, 0, 0);
        do_op(OP_MULTU, 32'h0000_0009, 32'h0000_0009, 0, 0);
        check("dz_kept_by_mul", 65'(div_zero), 65'(1));
        reset_mid_div();

        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0:       ra = 32'h8000_0000;
                1:       ra = $urandom_range(0, 15);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            rc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + 2)) : 0;
            rn = ($urandom_range(0, 3) == 0);
            do_op(ro, ra, rb, rc, rn);
        end

        check("queue_empty", 65'(exp_q.size()), 65'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
